// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// captures the returned instruction into the IF/ID register for decode.
module fetch_stage #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  PC_STEP     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    pc_out,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    input  logic                   halt_req,
    output logic                   ifid_valid,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [PC_WIDTH-1:0]    ifid_pc_next,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetchState_e;

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    fetchState_e            state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   ifidValid_q;
    logic [INSTR_WIDTH-1:0] ifidInstr_q;
    logic [PC_WIDTH-1:0]    ifidPc_q;
    logic [PC_WIDTH-1:0]    ifidPcNext_q;
    logic                   halted_q;
    logic [15:0]            fetchCount_q;

    logic [PC_WIDTH-1:0]    pcPlusStep_d;
    logic [PC_WIDTH-1:0]    alignedTarget_d;

    // Odd redirect targets are forced onto an instruction boundary.
    assign alignedTarget_d = redirect_target & ~PC_WIDTH'(1);
    assign pcPlusStep_d    = pc_q + STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifidValid_q  <= 1'b0;
            ifidInstr_q  <= '0;
            ifidPc_q     <= '0;
            ifidPcNext_q <= '0;
            halted_q     <= 1'b0;
            fetchCount_q <= '0;
        end else begin
            // A valid IF/ID entry is consumed when decode takes it and no flush kills it.
            if (ifidValid_q && !stall && !redirect_valid) begin
                fetchCount_q <= fetchCount_q + 16'd1;
            end

            case (state_q)
                RUN: begin
                    if (redirect_valid) begin
                        pc_q        <= alignedTarget_d;
                        ifidValid_q <= 1'b0;
                        ifidInstr_q <= '0;
                    end else if (halt_req) begin
                        state_q     <= HALTED;
                        halted_q    <= 1'b1;
                        ifidValid_q <= 1'b0;
                    end else if (!stall) begin
                        pc_q         <= pcPlusStep_d;
                        ifidValid_q  <= 1'b1;
                        ifidInstr_q  <= instr_in;
                        ifidPc_q     <= pc_q;
                        ifidPcNext_q <= pcPlusStep_d;
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc_q     <= alignedTarget_d;
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign pc_out       = pc_q;
    assign ifid_valid   = ifidValid_q;
    assign ifid_instr   = ifidInstr_q;
    assign ifid_pc      = ifidPc_q;
    assign ifid_pc_next = ifidPcNext_q;
    assign halted       = halted_q;
    assign fetch_count  = fetchCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic, every output
// compared each cycle against a simple integer-arithmetic reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt_req;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_next;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] imem [0:32767];

    int numChecks = 0;
    int numErrors = 0;

    // Reference model state, held as plain integers.
    int mPc, mValid, mInstr, mIfPc, mIfPcNext, mHalted, mCount;

    always #5 clk = ~clk;

    assign instr_in = imem[pc_out[15:1]];

    fetch_stage #(
        .PC_WIDTH   (16),
        .INSTR_WIDTH(16),
        .RESET_PC   (16'h0000),
        .PC_STEP    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_next   (ifid_pc_next),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit st, input bit rv, input int tgt, input bit hr);
        if (r) begin
            mPc = 0; mValid = 0; mInstr = 0; mIfPc = 0; mIfPcNext = 0; mHalted = 0; mCount = 0;
            return;
        end
        if (mValid == 1 && !st && !rv) mCount = (mCount + 1) % 65536;
        if (mHalted == 0) begin
            if (rv) begin
                mPc = tgt - (tgt % 2);
                mValid = 0;
                mInstr = 0;
            end else if (hr) begin
                mHalted = 1;
                mValid = 0;
            end else if (!st) begin
                mInstr = int'(imem[mPc / 2]);
                mIfPc = mPc;
                mIfPcNext = (mPc + 2) % 65536;
                mValid = 1;
                mPc = (mPc + 2) % 65536;
            end
        end else if (rv) begin
            mPc = tgt - (tgt % 2);
            mHalted = 0;
        end
    endtask

    task automatic compareAll();
        checkOutput("pc_out", 32'(pc_out), 32'(mPc));
        checkOutput("ifid_valid", 32'(ifid_valid), 32'(mValid));
        checkOutput("ifid_instr", 32'(ifid_instr), 32'(mInstr));
        checkOutput("ifid_pc", 32'(ifid_pc), 32'(mIfPc));
        checkOutput("ifid_pc_next", 32'(ifid_pc_next), 32'(mIfPcNext));
        checkOutput("halted", 32'(halted), 32'(mHalted));
        checkOutput("fetch_count", 32'(fetch_count), 32'(mCount));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare.
    task automatic applyStimulus(input bit r, input bit st, input bit rv, input logic [15:0] tgt, input bit hr);
        rst = r;
        stall = st;
        redirect_valid = rv;
        redirect_target = tgt;
        halt_req = hr;
        @(posedge clk);
        modelStep(r, st, rv, int'(tgt), hr);
        #1;
        compareAll();
    endtask

    task automatic runFree(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) imem[i] = 16'($urandom);
        imem[0] = 16'h3180;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt_req = 1'b0;
        mPc = 0; mValid = 0; mInstr = 0; mIfPc = 0; mIfPcNext = 0; mHalted = 0; mCount = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("reset_pc", 32'(pc_out), 32'h0);
        checkOutput("reset_valid", 32'(ifid_valid), 32'h0);
        checkOutput("reset_count", 32'(fetch_count), 32'h0);

        // Free run from reset.
        runFree(1);
        checkOutput("first_instr", 32'(ifid_instr), 32'h3180);
        checkOutput("first_valid", 32'(ifid_valid), 32'h1);
        runFree(4);
        checkOutput("count_after5", 32'(fetch_count), 32'd4);
        checkOutput("pc_after5", 32'(pc_out), 32'd10);

        // Stall holding at pc=6.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        runFree(3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("stall_pc", 32'(pc_out), 32'd6);
        checkOutput("stall_ifid_pc", 32'(ifid_pc), 32'd4);
        runFree(1);
        checkOutput("release_pc", 32'(pc_out), 32'd8);

        // Redirect to an odd target while stalled.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h001F, 1'b0);
        checkOutput("redir_pc", 32'(pc_out), 32'h1E);
        checkOutput("redir_flush_valid", 32'(ifid_valid), 32'h0);
        checkOutput("redir_flush_instr", 32'(ifid_instr), 32'h0);
        runFree(1);
        checkOutput("redir_ifid_pc", 32'(ifid_pc), 32'h1E);

        // Halt at pc=10, ignore stall/halt while halted, then resume.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h000A, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("halt_flag", 32'(halted), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'(i % 2), 1'b0, 16'h0, 1'(i / 2));
        checkOutput("halt_pc", 32'(pc_out), 32'd10);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        checkOutput("resume_halted", 32'(halted), 32'h0);
        checkOutput("resume_pc", 32'(pc_out), 32'h0);
        runFree(1);

        // PC wrap-around.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        runFree(1);
        checkOutput("wrap_ifid_pc", 32'(ifid_pc), 32'hFFFE);
        checkOutput("wrap_pc_next", 32'(ifid_pc_next), 32'h0);
        runFree(1);
        checkOutput("wrap_pc", 32'(pc_out), 32'h2);

        // Reset during a stall with a valid entry.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        runFree(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("pre_rst_pc", 32'(pc_out), 32'd20);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("midrst_pc", 32'(pc_out), 32'h0);
        checkOutput("midrst_valid", 32'(ifid_valid), 32'h0);
        checkOutput("midrst_count", 32'(fetch_count), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 1),
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 8),
                          16'($urandom),
                          ($urandom_range(0, 99) < 4));
        end

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit processor.
- Owns the program counter and drives it to the combinational instruction memory.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for decode.
- Handles stall, redirect (branch/jump), halt, and a retired-fetch counter.

Parameters:
- PC_WIDTH, 16: width of the program counter and addresses.
- INSTR_WIDTH, 16: instruction width.
- RESET_PC, 16'h0000: PC value loaded on reset. Bit 0 must be 0.
- PC_STEP, 2: byte increment per sequential fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_out  output  PC_WIDTH  current fetch address to instruction memory.
- instr_in  input  INSTR_WIDTH  instruction returned combinationally for pc_out.
- stall  input  1  decode cannot accept; hold PC and IF/ID.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  PC_WIDTH  new fetch address.
- halt_req  input  1  stop fetching after the current cycle.
- ifid_valid  output  1  IF/ID register holds a real instruction.
- ifid_instr  output  INSTR_WIDTH  latched instruction.
- ifid_pc  output  PC_WIDTH  address of ifid_instr.
- ifid_pc_next  output  PC_WIDTH  ifid_pc + PC_STEP, for link/branch base.
- halted  output  1  fetch is in HALTED state.
- fetch_count  output  16  number of instructions delivered with valid=1 and not stalled.

Behaviour:
- Reset (rst=1 at clock edge), taking priority over everything:
  - pc = RESET_PC, state = RUN.
  - ifid_valid = 0, ifid_instr = 0, ifid_pc = 0, ifid_pc_next = 0.
  - halted = 0, fetch_count = 0.
  - Reset asserted mid-operation discards all in-flight state.
- pc_out is driven directly from the PC register. There is no combinational path from inputs to pc_out.
- FSM states:
  - RUN: normal fetch.
  - HALTED: PC frozen.
- Priority in RUN, highest first: redirect_valid, halt_req, stall, normal.
- RUN, redirect_valid=1:
  - pc <= {redirect_target[PC_WIDTH-1:1], 1'b0}. An odd target is force-aligned.
  - IF/ID is flushed: ifid_valid <= 0, ifid_instr <= 0 (NOP encoding).
  - Redirect overrides stall.
- RUN, halt_req=1 (no redirect):
  - state <= HALTED, ifid_valid <= 0, pc holds.
- RUN, stall=1 (no redirect, no halt):
  - pc and all ifid_* hold their values.
  - fetch_count holds.
- RUN, normal:
  - ifid_instr <= instr_in, ifid_pc <= pc, ifid_pc_next <= pc + PC_STEP, ifid_valid <= 1.
  - pc <= pc + PC_STEP.
  - fetch_count increments if the previous ifid_valid=1 was consumed. Defined as: increments on every edge where ifid_valid=1 and stall=0 and redirect_valid=0.
- Latency: an instruction at address A appears on ifid_instr one clock after pc_out=A.
- HALTED:
  - pc holds; ifid_valid stays 0; halted = 1; stall and halt_req are ignored.
  - redirect_valid=1 sets pc to the aligned target and state <= RUN. The first valid IF/ID entry appears on the following edge.
- Wrap-around: pc = 16'hFFFE + 2 becomes 16'h0000 with no flag. ifid_pc_next wraps the same way.
- fetch_count wraps from 16'hFFFF to 0.
- Addition is modulo 2^PC_WIDTH throughout.

Test Plan:
- Reset then 5 free-running cycles with instr_in = 16'h3180 at pc 0: pc_out steps 0,2,4,6,8. ifid_pc lags by one clock. ifid_valid rises on the first edge after reset. fetch_count = 4 after the 5th edge.
- Hold stall=1 for 3 cycles at pc=6: pc_out stays 6, and ifid_instr/ifid_pc (=4) are unchanged. On release, pc_out becomes 8 next edge.
- redirect_valid=1 with target 16'h001F and stall=1 simultaneously: pc_out = 16'h001E next edge, ifid_valid = 0, ifid_instr = 0. The next edge gives ifid_pc = 16'h001E, valid = 1.
- halt_req=1 at pc=10: halted = 1 and ifid_valid = 0 next edge. pc_out stays 10 for 4 cycles despite stall toggling. A redirect to 16'h0000 returns to RUN with pc_out = 0.
- Redirect to 16'hFFFE then run 2 cycles: ifid_pc = 16'hFFFE with ifid_pc_next = 16'h0000, and pc_out = 16'h0002.
- Assert rst during a stall at pc=20 with ifid_valid=1: next edge gives pc_out = RESET_PC, ifid_valid = 0, fetch_count = 0, halted = 0.
